// File: rtl/deser_16.sv
// deser_16: serial-to-parallel receiver for the 16-bit bit-serial link.
//
// One bit is taken per accepted cycle and written into the slot of a 16-bit
// collector addressed by a 4-bit position counter. Each completed word is
// handed to a valid/ready output holding register. If that register is still
// occupied when a word completes, the word waits in the collector (STALL) and
// serial input is throttled until the consumer drains the holding register.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. This applies to the input side (sin_valid/sin_ready) and to
// the output side (dout_valid/dout_ready). sin_ready depends only on
// registered state and rst. dout_ready may affect word loading in the same
// cycle.
//
// Parameters:
//   LSB_FIRST   1: first bit of a frame lands in dout[0]; 0: in dout[15]
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   sync        frame realign: drop partial or stalled word, counter to 0
//   sin         serial data bit
//   sin_valid   sin is valid this cycle
//   sin_ready   block can accept a bit this cycle
//   dout        assembled word
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer takes dout this cycle
//   cnt         bits collected in the partial word (0-15)
//   dbg_stall   FSM state: 1 = STALL, 0 = COLLECT
module deser_16 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync,
  input  logic        sin,
  input  logic        sin_valid,
  output logic        sin_ready,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [3:0]  cnt,
  output logic        dbg_stall
);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_STALL   = 1'b1
  } state_e;

  state_e      state_q;
  logic [15:0] col_q;
  logic [15:0] dout_q;
  logic        dout_valid_q;
  logic [3:0]  cnt_q;

  logic [3:0]  idx_d;
  logic [15:0] word_d;
  logic        accept_d;
  logic        drain_d;
  logic        hold_free_d;

  // Slot addressed by the position counter; MSB-first mirrors the index.
  assign idx_d = LSB_FIRST ? cnt_q : (4'd15 - cnt_q);

  // Collector contents with the current bit already merged in; on the 16th
  // bit this is the completed word.
  always_comb begin
    word_d        = col_q;
    word_d[idx_d] = sin;
  end

  assign sin_ready   = (state_q == ST_COLLECT) && !rst;
  // sync has priority: the bit presented alongside it is ignored.
  assign accept_d    = sin_valid && sin_ready && !sync;
  assign drain_d     = dout_valid_q && dout_ready;
  // The holding register can take a new word if it is empty or being read.
  assign hold_free_d = !dout_valid_q || dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      col_q        <= 16'h0000;
      dout_q       <= 16'h0000;
      dout_valid_q <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      // Drain without refill; overridden below when a new word loads.
      if (drain_d) begin
        dout_valid_q <= 1'b0;
      end
      if (sync) begin
        cnt_q   <= 4'd0;
        col_q   <= 16'h0000;
        state_q <= ST_COLLECT;
      end else begin
        case (state_q)
          ST_COLLECT: begin
            if (accept_d) begin
              col_q <= word_d;
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd15) begin
                if (hold_free_d) begin
                  dout_q       <= word_d;
                  dout_valid_q <= 1'b1;
                end else begin
                  // Completed word parks in the collector until a drain.
                  state_q <= ST_STALL;
                end
              end
            end
          end
          ST_STALL: begin
            // Refill from the collector; no bit is accepted this cycle.
            if (drain_d) begin
              dout_q       <= col_q;
              dout_valid_q <= 1'b1;
              state_q      <= ST_COLLECT;
            end
          end
          default: state_q <= ST_COLLECT;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign cnt        = cnt_q;
  assign dbg_stall  = (state_q == ST_STALL);

endmodule

// File: tb/tb_deser_16.sv
module tb_deser_16;

  logic        clk;
  logic        rst;
  logic        sync;
  logic        sin;
  logic        sin_valid;
  logic        sin_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [3:0]  cnt;
  logic        dbg_stall;

  logic        m_sin_ready;
  logic [15:0] m_dout;
  logic        m_dout_valid;
  logic [3:0]  m_cnt;
  logic        m_dbg_stall;

  int checks;
  int failures;
  int valid_cycles;
  int ready_drops;
  logic word_seen;
  logic taken;

  logic [15:0] exp_q[$];

  deser_16 #(.LSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .sync(sync), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(sin_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .cnt(cnt), .dbg_stall(dbg_stall)
  );

  // MSB-first instance sees the same stimulus; its words are bit-reversed.
  deser_16 #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .sync(sync), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(m_sin_ready), .dout(m_dout), .dout_valid(m_dout_valid),
    .dout_ready(dout_ready), .cnt(m_cnt), .dbg_stall(m_dbg_stall)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15 - i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Presents one bit and returns #1 after the edge that accepts it.
  // sin_valid is left high so consecutive calls stream without bubbles.
  task automatic send_bit(input logic b);
    int n;
    n = 0;
    sin       = b;
    sin_valid = 1'b1;
    while (!sin_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 16'd1, 16'd0);
    tick();
  endtask

  task automatic send_word(input logic [15:0] w, input logic push);
    if (push) exp_q.push_back(w);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  // ---------------- scoreboard monitor ----------------
  // A new word is visible when dout_valid is high and the previous word has
  // not been reported yet, or a transfer occurred on the previous edge.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      word_seen = 1'b0;
      taken     = 1'b0;
    end else begin
      if (taken) word_seen = 1'b0;
      if (dout_valid) valid_cycles++;
      if (sin_valid && !sin_ready) ready_drops++;
      if (dout_valid && !word_seen) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", dout, 16'hxxxx);
        end else begin
          e = exp_q.pop_front();
          check("sb_dout", dout, e);
          check("sb_msb_dout", m_dout, rev16(e));
        end
        word_seen = 1'b1;
      end
      taken = dout_valid && dout_ready;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] w;
    checks       = 0;
    failures     = 0;
    valid_cycles = 0;
    ready_drops  = 0;
    word_seen    = 1'b0;
    taken        = 1'b0;
    rst          = 1'b1;
    sync         = 1'b0;
    sin          = 1'b0;
    sin_valid    = 1'b0;
    dout_ready   = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_sin_ready", {15'd0, sin_ready}, 16'd0);
    check("rst_dout", dout, 16'h0000);
    check("rst_dout_valid", {15'd0, dout_valid}, 16'd0);
    check("rst_cnt", {12'd0, cnt}, 16'd0);
    rst = 1'b0;
    #1;
    check("post_rst_sin_ready", {15'd0, sin_ready}, 16'd1);

    // Single word 0xA5C3, LSB-first, counter walk and one-cycle pulse
    w = 16'hA5C3;
    exp_q.push_back(w);
    for (int i = 0; i < 16; i++) begin
      send_bit(w[i]);
      check("cnt_walk", {12'd0, cnt}, 16'((i + 1) % 16));
    end
    sin_valid = 1'b0;
    check("a5c3_dout", dout, 16'hA5C3);
    check("a5c3_valid", {15'd0, dout_valid}, 16'd1);
    tick();
    check("a5c3_pulse_end", {15'd0, dout_valid}, 16'd0);
    check("a5c3_dout_kept", dout, 16'hA5C3);

    // Back-to-back words with sin_valid held high for 32 cycles
    valid_cycles = 0;
    ready_drops  = 0;
    send_word(16'h1234, 1'b1);
    check("b2b_first", dout, 16'h1234);
    send_word(16'hFFFF, 1'b1);
    sin_valid = 1'b0;
    check("b2b_second", dout, 16'hFFFF);
    tick();
    check("b2b_valid_cycles", 16'(valid_cycles), 16'd2);
    check("b2b_ready_drops", 16'(ready_drops), 16'd0);

    // Backpressure: second word stalls in the collector
    dout_ready = 1'b0;
    send_word(16'h00FF, 1'b1);
    sin_valid = 1'b0;
    check("bp_first_loaded", dout, 16'h00FF);
    tick();
    send_word(16'hF0F0, 1'b1);
    sin_valid = 1'b0;
    check("bp_hold", dout, 16'h00FF);
    check("bp_stall", {15'd0, dbg_stall}, 16'd1);
    check("bp_sin_ready_low", {15'd0, sin_ready}, 16'd0);
    check("bp_valid_held", {15'd0, dout_valid}, 16'd1);
    tick();
    check("bp_still_stalled", {15'd0, sin_ready}, 16'd0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("bp_refill_dout", dout, 16'hF0F0);
    check("bp_refill_valid", {15'd0, dout_valid}, 16'd1);
    check("bp_stall_clear", {15'd0, dbg_stall}, 16'd0);
    check("bp_sin_ready_back", {15'd0, sin_ready}, 16'd1);
    tick();
    check("bp_refill_held", dout, 16'hF0F0);
    dout_ready = 1'b1;
    tick();
    check("bp_drained", {15'd0, dout_valid}, 16'd0);

    // sync mid-word: partial bits and the bit alongside sync are dropped
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
    check("sync_pre_cnt", {12'd0, cnt}, 16'd7);
    sin  = 1'b1;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_cnt", {12'd0, cnt}, 16'd0);
    send_word(16'h8001, 1'b1);
    sin_valid = 1'b0;
    check("sync_word", dout, 16'h8001);

    // One-hot first bit: MSB-first instance puts it in bit 15
    send_word(16'h0001, 1'b1);
    sin_valid = 1'b0;
    check("msb_first_word", m_dout, 16'h8000);
    check("lsb_first_word", dout, 16'h0001);
    tick();

    // sync while stalled drops the stalled word
    dout_ready = 1'b0;
    send_word(16'h3C3C, 1'b1);
    send_word(16'hDEAD, 1'b0);
    sin_valid = 1'b0;
    check("sync_stall_set", {15'd0, dbg_stall}, 16'd1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_stall_clear", {15'd0, dbg_stall}, 16'd0);
    check("sync_stall_dout", dout, 16'h3C3C);
    check("sync_stall_valid", {15'd0, dout_valid}, 16'd1);
    dout_ready = 1'b1;
    tick();
    check("sync_stall_drained", {15'd0, dout_valid}, 16'd0);

    // Reset mid-word with an unconsumed word held
    dout_ready = 1'b0;
    send_word(16'h1111, 1'b1);
    for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)));
    sin_valid = 1'b0;
    check("rw_valid_before", {15'd0, dout_valid}, 16'd1);
    check("rw_cnt_before", {12'd0, cnt}, 16'd9);
    rst = 1'b1;
    tick();
    check("rw_sin_ready_in_rst", {15'd0, sin_ready}, 16'd0);
    tick();
    rst = 1'b0;
    dout_ready = 1'b1;
    #1;
    check("rw_dout", dout, 16'h0000);
    check("rw_dout_valid", {15'd0, dout_valid}, 16'd0);
    check("rw_cnt", {12'd0, cnt}, 16'd0);
    check("rw_stall", {15'd0, dbg_stall}, 16'd0);
    send_word(16'h5555, 1'b1);
    sin_valid = 1'b0;
    check("rw_word", dout, 16'h5555);
    check("rw_msb_word", m_dout, 16'hAAAA);
    tick();
    tick();

    check("sb_queue_empty", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
